// File: rtl/serial_frame_sender_if.sv
// Handshake/bus bundle for serial_frame_sender: frame request inputs and serial/status outputs.
interface serial_frame_sender_if #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 15
);
    logic              clk_en;
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [LEN_W-1:0]  len_in;
    logic              ser_out;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  bit_cnt;

    modport master (
        output clk_en, start, data_in, len_in,
        input  ser_out, busy, done, bit_cnt
    );

    modport slave (
        input  clk_en, start, data_in, len_in,
        output ser_out, busy, done, bit_cnt
    );
endinterface

// File: rtl/serial_frame_sender.sv
// Serial frame sender: start pattern, length field, LSB-first payload, stepped by clk_en.
// Optional trailing even-parity bit when SERIAL_FRAME_PARITY_EN is defined.
module serial_frame_sender #(
    parameter logic [3:0]  PATTERN = 4'b1101,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned DATA_W  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_frame_sender_if.slave   bus
);

    localparam int unsigned IDX_W = (LEN_W > 4) ? $clog2(LEN_W) : 2;
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(3);
    localparam logic [IDX_W-1:0] LEN_LAST = IDX_W'(LEN_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
`ifdef SERIAL_FRAME_PARITY_EN
        PAR  = 3'd4,
`endif
        FIN  = 3'd5
    } state_t;

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [LEN_W-1:0]  cnt_q, cnt_n;
    logic              ser_q, ser_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
`ifdef SERIAL_FRAME_PARITY_EN
    logic              par_q, par_n;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            len_q   <= len_n;
            cnt_q   <= cnt_n;
            ser_q   <= ser_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // Next-state logic; outputs are decoded from next-state values so they register glitch-free
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        ser_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
        par_n   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = HDR;
                    idx_n   = '0;
                    shift_n = bus.data_in;
                    len_n   = bus.len_in;
                    cnt_n   = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                    par_n   = 1'b0;
`endif
                end
            end
            HDR: begin
                if (bus.clk_en) begin
                    if (idx_q == HDR_LAST) begin
                        state_n = LEN;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            LEN: begin
                if (bus.clk_en) begin
                    if (idx_q == LEN_LAST) begin
                        idx_n = '0;
                        if (len_q != '0) begin
                            state_n = DATA;
                        end else begin
`ifdef SERIAL_FRAME_PARITY_EN
                            state_n = PAR;
`else
                            state_n = FIN;
`endif
                        end
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.clk_en) begin
                    shift_n = shift_q >> 1;
                    cnt_n   = cnt_q + LEN_W'(1);
`ifdef SERIAL_FRAME_PARITY_EN
                    par_n   = par_q ^ shift_q[0];
`endif
                    if (cnt_n == len_q) begin
`ifdef SERIAL_FRAME_PARITY_EN
                        state_n = PAR;
`else
                        state_n = FIN;
`endif
                    end
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PAR: begin
                if (bus.clk_en) begin
                    state_n = FIN;
                end
            end
`endif
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            HDR:  ser_n = PATTERN[2'(HDR_LAST - idx_n)];
            LEN:  ser_n = len_n[LEN_LAST - idx_n];
            DATA: ser_n = shift_n[0];
`ifdef SERIAL_FRAME_PARITY_EN
            PAR:  ser_n = par_n;
`endif
            default: ser_n = 1'b0;
        endcase

        busy_n = (state_n != IDLE) && (state_n != FIN);
        done_n = (state_n == FIN);
    end

    assign bus.ser_out = ser_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender; expected serial bits queued at stimulus, popped per bit-time.
module tb_serial_frame_sender;

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    serial_frame_sender_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    serial_frame_sender #(
        .PATTERN (4'b1101),
        .LEN_W   (LEN_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected line bits of one frame
    task automatic push_frame(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        logic [3:0] pat;
        logic       par;
        pat = 4'b1101;
        par = 1'b0;
        for (int i = 3; i >= 0; i--) exp_q.push_back(pat[i]);
        for (int i = LEN_W - 1; i >= 0; i--) exp_q.push_back(l[i]);
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(d[i]);
            par = par ^ d[i];
        end
`ifdef SERIAL_FRAME_PARITY_EN
        exp_q.push_back(par);
`endif
    endtask

    // Send one frame with clk_en every p clocks; optionally pulse start again mid-frame
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l,
                              input int p, input logic en_with_start, input logic restart);
        int   nbits;
        int   exp_cnt;
        logic exp_bit;
        push_frame(d, l);
        nbits = exp_q.size();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.len_in  = l;
        bus.clk_en  = en_with_start;
        for (int b = 0; b < nbits; b++) begin
            exp_bit = exp_q.pop_front();
            exp_cnt = (b < 4 + int'(LEN_W)) ? 0 : b - 4 - int'(LEN_W);
            if (exp_cnt > int'(l)) exp_cnt = int'(l);
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                chk($sformatf("ser_b%0d_c%0d", b, c), 32'(bus.ser_out), 32'(exp_bit));
                chk("busy_in_frame", 32'(bus.busy), 32'd1);
                chk("done_in_frame", 32'(bus.done), 32'd0);
                chk($sformatf("bit_cnt_b%0d", b), 32'(bus.bit_cnt), 32'(exp_cnt));
                bus.start   = restart && (b == 5) && (c == 0);
                bus.data_in = (restart && b == 5) ? ~d : d;
                bus.len_in  = (restart && b == 5) ? ~l : l;
                bus.clk_en  = (c == p - 1);
            end
        end
        @(negedge clk);
        bus.clk_en = 1'b0;
        chk("fin_done", 32'(bus.done), 32'd1);
        chk("fin_busy", 32'(bus.busy), 32'd0);
        chk("fin_ser", 32'(bus.ser_out), 32'd0);
        chk("fin_bit_cnt", 32'(bus.bit_cnt), 32'(l));
        @(negedge clk);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_bit_cnt", 32'(bus.bit_cnt), 32'(l));
        chk("idle_ser", 32'(bus.ser_out), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.clk_en  = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.len_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ser", 32'(bus.ser_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        rst = 1'b0;

        // Idle with clk_en pulsing and no start: line stays quiet
        bus.clk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start_busy", 32'(bus.busy), 32'd0);
        chk("idle_no_start_ser", 32'(bus.ser_out), 32'd0);
        bus.clk_en = 1'b0;

        // Reset mid-DATA on a len=5 frame
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 15'b10110;
        bus.len_in  = 4'd5;
        bus.clk_en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        chk("pre_rst_bit_cnt", 32'(bus.bit_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ser", 32'(bus.ser_out), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(bus.done), 32'd0);
        end
        rst        = 1'b0;
        bus.clk_en = 1'b0;

        // Clean frame after reset, clk_en held high
        send_frame(15'b101, 4'd3, 1, 1'b1, 1'b0);

        // Zero-length frame
        send_frame(15'h5A5A, 4'd0, 1, 1'b1, 1'b0);

        // Hand-stepped full-length frame of ones
        send_frame(15'h7FFF, 4'd15, 7, 1'b0, 1'b0);

        // start with clk_en in IDLE, then a second start while busy
        send_frame(15'b10, 4'd2, 3, 1'b1, 1'b1);

        // Mixed payload stepped every other clock
        send_frame(15'h2C3A, 4'd9, 2, 1'b0, 1'b0);

`ifdef SERIAL_FRAME_PARITY_EN
        send_frame(15'b1011, 4'd4, 1, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
